instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Assembles MIPS-subset instruction words from decoded fields and writes them sequentially into
//  instruction memory (opposite direction of the instruction decode stage). Testbench/boot-loader
//  block: field tuples in over valid/ready, 32-bit words out on an IMEM write port with backpressure.
//  Covers exactly the subset the decode stage understands.
// PARAMETERS
//  DWIDTH      32   instruction/data word width
//  IMEM_DEPTH  256  words writable before full (power of 2 not required)
//  BASE_ADDR   0    byte address of first written word
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  clr          in   1       sync clear: pointer, err, FSM -> IDLE
//  in_valid     in   1       field tuple valid
//  in_ready     out  1       tuple accepted when in_valid & in_ready
//  in_mnem      in   4       0 add,1 sub,2 and,3 or,4 nor,5 slt,6 jr,7 addi,8 slti,9 lw,10 sw,11 beq,12 j,13 jal
//  in_rs        in   5       rs field
//  in_rt        in   5       rt field
//  in_rd        in   5       rd field (R-type only)
//  in_imm       in   16      immediate (I-type only)
//  in_target    in   26      jump target word index (j/jal only)
//  imem_we      out  1       write request, held until imem_ready
//  imem_ready   in   1       memory accepts write this cycle when imem_we & imem_ready
//  imem_addr    out  32      byte address = BASE_ADDR + 4*wr_ptr
//  imem_wdata   out  DWIDTH  encoded instruction word
//  wr_count     out  9       words written since rst/clr (width clog2(IMEM_DEPTH+1))
//  full         out  1       wr_count == IMEM_DEPTH
//  err_illegal  out  1       sticky: mnemonic 14/15 was accepted
// BEHAVIOUR
//  Reset: all outputs 0 (in_ready 0 during rst), wr_ptr 0, FSM IDLE; in_ready=1 first cycle after.
//  FSM: IDLE  -accept legal-> WRITE; accept illegal -> stay IDLE, set err_illegal, nothing written.
//       WRITE -imem_ready, wr_ptr+1==IMEM_DEPTH-> FULL; -imem_ready & accept legal-> WRITE (next word);
//             -imem_ready, no new legal accept-> IDLE; -!imem_ready-> WRITE, word/addr held stable.
//       FULL  : in_ready=0, full=1; exit only via clr or rst.
//  in_ready = !clr & (IDLE | (WRITE & imem_ready & wr_ptr+1<IMEM_DEPTH)) -> 1 word/cycle sustained.
//  Latency: tuple accepted at edge N -> imem_we=1 with word on cycle N+1 (registered outputs).
//  wr_ptr/wr_count increment only on imem_we & imem_ready; imem_we=0 in IDLE/FULL.
//  Encoding: R-type {6'h00,rs,rt,rd,5'h0,funct}: add 20,sub 22,and 24,or 25,nor 27,slt 2A (hex).
//    jr {6'h00,rs,15'h0,6'h08}; I-type {op,rs,rt,imm}: addi 08,slti 0A,lw 23,sw 2B,beq 04;
//    beq uses rs,rt order as given; j {6'h02,target}; jal {6'h03,target}. Unused fields forced 0.
//  imm is emitted raw (16 bits); no sign handling here. Registers unchecked (any 0..31 legal).
//  clr: takes priority over everything; pending WRITE word dropped (imem_we low next cycle),
//    no tuple accepted that cycle, wr_ptr/count/err cleared, FSM->IDLE.
//  Illegal accept while in WRITE: current word completes; err set; FSM -> IDLE after it.
//  rst mid-write: imem_we drops immediately (async); word lost.
// TESTING
//  add rs=1 rt=2 rd=3 -> imem_wdata 32'h00221820, imem_addr BASE_ADDR, imem_we 1 cycle after accept.
//  addi rs=0 rt=8 imm=FFFF, then lw rs=29 rt=9 imm=0004, imem_ready=1 -> 2008FFFF @+0, 8FA90004 @+4, back-to-back.
//  jal target=26'h40 with imem_ready low 3 cycles -> 0C000040 held stable, in_ready 0, count +1 only on ready.
//  IMEM_DEPTH=4, stream 6 adds -> 4 written (addr 0..C), full=1, in_ready=0 thereafter; clr -> count 0, in_ready 1.
//  mnem=14 then sub 1,2,3 -> err_illegal=1, only 00221822 written, at addr BASE_ADDR.
//  clr asserted while WRITE stalled -> imem_we 0 next cycle, wr_count 0, simultaneous in_valid not accepted.

Source files
------------

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-tuple input handshake and instruction-memory write port.
interface instr_encoder_if #(
    parameter int DWIDTH = 32,
    parameter int CW     = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_mnem;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic              imem_ready;
    logic [31:0]       imem_addr;
    logic [DWIDTH-1:0] imem_wdata;
    logic [CW-1:0]     wr_count;
    logic              full;
    logic              err_illegal;
    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, wr_count, full, err_illegal
    );
    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, wr_count, full, err_illegal
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: assembles MIPS-subset words from decoded fields and streams them into IMEM.
module instr_encoder #(
    parameter int          DWIDTH     = 32,
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input logic            clk,
    input logic            rst,
    input logic            clr,
    instr_encoder_if.slave bus
);
    localparam int CW = $clog2(IMEM_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;
    state_t            state, state_n;
    logic [CW-1:0]     ptr;
    logic [DWIDTH-1:0] word;
    logic              err;
    logic              done, last, accept, legal;
    function automatic logic [31:0] enc(input logic [3:0] m, input logic [4:0] rs, rt, rd,
                                        input logic [15:0] imm, input logic [25:0] t);
        case (m)
            4'd0:    enc = {6'h00, rs, rt, rd, 5'h0, 6'h20};
            4'd1:    enc = {6'h00, rs, rt, rd, 5'h0, 6'h22};
            4'd2:    enc = {6'h00, rs, rt, rd, 5'h0, 6'h24};
            4'd3:    enc = {6'h00, rs, rt, rd, 5'h0, 6'h25};
            4'd4:    enc = {6'h00, rs, rt, rd, 5'h0, 6'h27};
            4'd5:    enc = {6'h00, rs, rt, rd, 5'h0, 6'h2A};
            4'd6:    enc = {6'h00, rs, 15'h0, 6'h08};
            4'd7:    enc = {6'h08, rs, rt, imm};
            4'd8:    enc = {6'h0A, rs, rt, imm};
            4'd9:    enc = {6'h23, rs, rt, imm};
            4'd10:   enc = {6'h2B, rs, rt, imm};
            4'd11:   enc = {6'h04, rs, rt, imm};
            4'd12:   enc = {6'h02, t};
            4'd13:   enc = {6'h03, t};
            default: enc = 32'h0;
        endcase
    endfunction
    assign done         = state == WRITE && bus.imem_ready;
    assign last         = 32'(ptr) + 1 == IMEM_DEPTH;
    assign bus.in_ready = !rst && !clr && (state == IDLE || (done && !last));
    assign accept       = bus.in_valid && bus.in_ready;
    assign legal        = bus.in_mnem < 4'd14;
    // accept implies IDLE or a completing write, so one chain covers every transition
    always_comb begin
        state_n = state;
        state_n = clr ? IDLE :
                  (done && last) ? FULL :
                  (accept && legal) ? WRITE :
                  (state == IDLE || done) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            word  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            if (clr) begin
                ptr <= '0;
                err <= 1'b0;
            end else begin
                if (done) ptr <= ptr + 1'b1;
                if (accept && legal)
                    word <= DWIDTH'(enc(bus.in_mnem, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm, bus.in_target));
                if (accept && !legal) err <= 1'b1;
            end
        end
    end
    assign bus.imem_we     = state == WRITE;
    assign bus.imem_addr   = BASE_ADDR + (32'(ptr) << 2);
    assign bus.imem_wdata  = word;
    assign bus.wr_count    = ptr;
    assign bus.full        = state == FULL;
    assign bus.err_illegal = err;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven encoding checks plus handshake, stall, full, clr and rst sequences.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h40;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    int total = 0;
    int bad = 0;
    instr_encoder_if #(.DWIDTH(32), .CW(3)) bus();
    instr_encoder #(.DWIDTH(32), .IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [3:0]  m;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] t;
        logic [31:0] w;
    } vec_t;
    vec_t v[$];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic send(input logic [3:0] m, input logic [4:0] rs, rt, rd,
                        input logic [15:0] imm, input logic [25:0] t);
        bus.in_valid  = 1'b1;
        bus.in_mnem   = m;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.in_target = t;
    endtask
    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask
    initial begin
        int writes, accepts;
        bus.in_valid = 1'b0;
        bus.imem_ready = 1'b1;
        send(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        bus.in_valid = 1'b0;
        // unused fields carry junk so forcing them to zero is visible
        v.push_back('{4'd0,  5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h022AF820});
        v.push_back('{4'd1,  5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h022AF822});
        v.push_back('{4'd2,  5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h022AF824});
        v.push_back('{4'd3,  5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h022AF825});
        v.push_back('{4'd4,  5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h022AF827});
        v.push_back('{4'd5,  5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h022AF82A});
        v.push_back('{4'd6,  5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h02200008});
        v.push_back('{4'd7,  5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h222ABEEF});
        v.push_back('{4'd8,  5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h2A2ABEEF});
        v.push_back('{4'd9,  5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h8E2ABEEF});
        v.push_back('{4'd10, 5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'hAE2ABEEF});
        v.push_back('{4'd11, 5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h122ABEEF});
        v.push_back('{4'd12, 5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h0AABCDEF});
        v.push_back('{4'd13, 5'h11, 5'h0A, 5'h1F, 16'hBEEF, 26'h2ABCDEF, 32'h0EABCDEF});
        v.push_back('{4'd0,  5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       32'h00221820});
        v.push_back('{4'd7,  5'd0,  5'd8,  5'd0,  16'hFFFF, 26'h0,       32'h2008FFFF});
        v.push_back('{4'd9,  5'd29, 5'd9,  5'd0,  16'h0004, 26'h0,       32'h8FA90004});
        v.push_back('{4'd13, 5'd0,  5'd0,  5'd0,  16'h0,    26'h40,      32'h0C000040});
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_we", 32'(bus.imem_we), 0);
        chk("rst_count", 32'(bus.wr_count), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_err", 32'(bus.err_illegal), 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        tick();
        foreach (v[i]) begin
            do_clr();
            send(v[i].m, v[i].rs, v[i].rt, v[i].rd, v[i].imm, v[i].t);
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_we", i), 32'(bus.imem_we), 1);
            chk($sformatf("vec%0d_word", i), bus.imem_wdata, v[i].w);
            chk($sformatf("vec%0d_addr", i), bus.imem_addr, BASE);
            tick();
            chk($sformatf("vec%0d_count", i), 32'(bus.wr_count), 1);
        end
        // back-to-back addi then lw
        do_clr();
        send(4'd7, 5'd0, 5'd8, 5'd0, 16'hFFFF, 26'h0);
        tick();
        send(4'd9, 5'd29, 5'd9, 5'd0, 16'h0004, 26'h0);
        #1;
        chk("b2b_we0", 32'(bus.imem_we), 1);
        chk("b2b_word0", bus.imem_wdata, 32'h2008FFFF);
        chk("b2b_addr0", bus.imem_addr, BASE);
        chk("b2b_in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_we1", 32'(bus.imem_we), 1);
        chk("b2b_word1", bus.imem_wdata, 32'h8FA90004);
        chk("b2b_addr1", bus.imem_addr, BASE + 4);
        chk("b2b_count1", 32'(bus.wr_count), 1);
        tick();
        chk("b2b_we_done", 32'(bus.imem_we), 0);
        chk("b2b_count2", 32'(bus.wr_count), 2);
        // jal under backpressure
        do_clr();
        bus.imem_ready = 1'b0;
        send(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_we", k), 32'(bus.imem_we), 1);
            chk($sformatf("stall%0d_word", k), bus.imem_wdata, 32'h0C000040);
            chk($sformatf("stall%0d_addr", k), bus.imem_addr, BASE);
            chk($sformatf("stall%0d_in_ready", k), 32'(bus.in_ready), 0);
            chk($sformatf("stall%0d_count", k), 32'(bus.wr_count), 0);
            tick();
        end
        bus.imem_ready = 1'b1;
        tick();
        chk("stall_release_count", 32'(bus.wr_count), 1);
        chk("stall_release_we", 32'(bus.imem_we), 0);
        // stream adds until full
        do_clr();
        writes = 0;
        accepts = 0;
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        #1;
        for (int c = 0; c < 10; c++) begin
            if (bus.imem_we) begin
                chk($sformatf("full_addr%0d", writes), bus.imem_addr, BASE + 32'(4 * writes));
                writes++;
            end
            if (bus.in_ready) accepts++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("full_writes", 32'(writes), 4);
        chk("full_accepts", 32'(accepts), 4);
        chk("full_flag", 32'(bus.full), 1);
        chk("full_count", 32'(bus.wr_count), 4);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_we", 32'(bus.imem_we), 0);
        do_clr();
        #1;
        chk("full_clr_count", 32'(bus.wr_count), 0);
        chk("full_clr_flag", 32'(bus.full), 0);
        chk("full_clr_in_ready", 32'(bus.in_ready), 1);
        tick();
        // illegal from IDLE, then legal sub
        send(4'd14, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        chk("ill_err", 32'(bus.err_illegal), 1);
        chk("ill_we", 32'(bus.imem_we), 0);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        bus.in_valid = 1'b0;
        chk("ill_sub_we", 32'(bus.imem_we), 1);
        chk("ill_sub_word", bus.imem_wdata, 32'h00221822);
        chk("ill_sub_addr", bus.imem_addr, BASE);
        tick();
        chk("ill_count", 32'(bus.wr_count), 1);
        chk("ill_err_sticky", 32'(bus.err_illegal), 1);
        do_clr();
        chk("ill_clr_err", 32'(bus.err_illegal), 0);
        // illegal accepted while a write completes
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        tick();
        bus.in_valid = 1'b0;
        chk("ill_w_err", 32'(bus.err_illegal), 1);
        chk("ill_w_we", 32'(bus.imem_we), 0);
        chk("ill_w_count", 32'(bus.wr_count), 1);
        // clr while stalled, with a simultaneous tuple offered
        do_clr();
        bus.imem_ready = 1'b0;
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        chk("clr_pre_we", 32'(bus.imem_we), 1);
        clr = 1'b1;
        #1;
        chk("clr_in_ready", 32'(bus.in_ready), 0);
        tick();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_we", 32'(bus.imem_we), 0);
        chk("clr_count", 32'(bus.wr_count), 0);
        bus.imem_ready = 1'b1;
        tick();
        chk("clr_no_accept_we", 32'(bus.imem_we), 0);
        // async reset mid-write
        bus.imem_ready = 1'b0;
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        bus.in_valid = 1'b0;
        chk("rstw_pre_we", 32'(bus.imem_we), 1);
        rst = 1'b1;
        #1;
        chk("rstw_we", 32'(bus.imem_we), 0);
        chk("rstw_in_ready", 32'(bus.in_ready), 0);
        #1;
        rst = 1'b0;
        bus.imem_ready = 1'b1;
        tick();
        chk("rstw_after_we", 32'(bus.imem_we), 0);
        chk("rstw_after_count", 32'(bus.wr_count), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
